// File: rtl/jk_pkg.sv
// Shared JK flip-flop command encoding and next-state function,
// used by the counter RTL and by behavioural models.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            JK_HOLD: r = q;
            JK_RST:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TOG:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle of the JK modulo counter: the controller side
// drives en/up/load/din, the counter side returns its state and flags.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_bar;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, din,
        input  count, count_bar, tc, wrap
    );

    modport slave (
        input  en, up, load, din,
        output count, count_bar, tc, wrap
    );
endinterface

// File: rtl/jk_mod_counter_cell.sv
// One JK flip-flop storage cell with asynchronous active-low reset;
// qbar is always the complement of q.
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);
    logic q_q;

    // JK state update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= jk_next(q_q, j, k);
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter: per-bit JK excitation logic driving a bank of
// JK cells, with combinational terminal count and a registered wrap pulse.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic        clk,
    input  logic        reset,
    jk_mod_counter_if.slave bus
);
    // WIDTH-bit constants keep the MOD-1 compare overflow-free at MOD = 2^WIDTH
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] qb_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic             tc_s;
    logic             wrap_d;
    logic             wrap_q;

    // Next state and JK excitation: load forces bits, count toggles changing bits
    always_comb begin
        next_s = q_s;
        j_s    = ZERO_C;
        k_s    = ZERO_C;
        if (bus.load) begin
            next_s = (bus.din > MAX_C) ? MAX_C : bus.din;
            j_s    = next_s;
            k_s    = ~next_s;
        end else if (bus.en) begin
            if (bus.up) begin
                next_s = (q_s == MAX_C) ? ZERO_C : (q_s + ONE_C);
            end else begin
                next_s = (q_s == ZERO_C) ? MAX_C : (q_s - ONE_C);
            end
            j_s = q_s ^ next_s;
            k_s = q_s ^ next_s;
        end else begin
            next_s = q_s;
        end
    end

    assign tc_s   = bus.en & ~bus.load &
                    ((bus.up & (q_s == MAX_C)) | (~bus.up & (q_s == ZERO_C)));
    assign wrap_d = tc_s;

    // Wrap pulse: terminal count taken on the previous edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_ff_cell u_cell (
            .clk  (clk),
            .reset(reset),
            .j    (j_s[gi]),
            .k    (k_s[gi]),
            .q    (q_s[gi]),
            .qbar (qb_s[gi])
        );
    end

    assign bus.count     = q_s;
    assign bus.count_bar = qb_s;
    assign bus.tc        = tc_s;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench: directed scenarios plus random stimulus on a MOD=10
// and a MOD=16 counter, compared against an arithmetic modulo reference.
module tb_jk_mod_counter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   m10;
    int   m16;
    bit   w10;
    bit   w16;

    jk_mod_counter_if #(.WIDTH(4)) bus10 ();
    jk_mod_counter_if #(.WIDTH(4)) bus16 ();

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (.clk(clk), .reset(reset), .bus(bus10));
    jk_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit tc_ref(int m, int md, bit e, bit u, bit l);
        return e && !l && ((u && m == md - 1) || (!u && m == 0));
    endfunction

    function automatic int next_ref(int m, int md, bit e, bit u, bit l, int d);
        if (l) return (d < md) ? d : md - 1;
        if (!e) return m;
        return u ? (m + 1) % md : (m + md - 1) % md;
    endfunction

    function automatic bit wrap_ref(int m, int md, bit e, bit u, bit l);
        if (l || !e) return 1'b0;
        return u ? (m + 1 == md) : (m == 0);
    endfunction

    task automatic drive(input bit e, input bit u, input bit l, input logic [3:0] d);
        bus10.en = e; bus10.up = u; bus10.load = l; bus10.din = d;
        bus16.en = e; bus16.up = u; bus16.load = l; bus16.din = d;
    endtask

    // One clock cycle: tc before the edge, state/wrap after it
    task automatic cyc(input bit e, input bit u, input bit l, input logic [3:0] d);
        drive(e, u, l, d);
        #1;
        chk("tc10", 32'(bus10.tc), 32'(tc_ref(m10, 10, e, u, l)));
        chk("tc16", 32'(bus16.tc), 32'(tc_ref(m16, 16, e, u, l)));
        @(posedge clk);
        w10 = wrap_ref(m10, 10, e, u, l);
        w16 = wrap_ref(m16, 16, e, u, l);
        m10 = next_ref(m10, 10, e, u, l, int'(d));
        m16 = next_ref(m16, 16, e, u, l, int'(d));
        #1;
        chk("count10", 32'(bus10.count), 32'(m10));
        chk("bar10", 32'(bus10.count_bar), 32'((~m10) & 15));
        chk("wrap10", 32'(bus10.wrap), 32'(w10));
        chk("count16", 32'(bus16.count), 32'(m16));
        chk("wrap16", 32'(bus16.wrap), 32'(w16));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m10 = 0; m16 = 0; w10 = 1'b0; w16 = 1'b0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_count", 32'(bus10.count), 32'd0);
        chk("rst_wrap", 32'(bus10.wrap), 32'd0);

        // Count a little, then reset asynchronously mid-cycle
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        #2 reset = 1'b0;
        #1;
        m10 = 0; m16 = 0; w10 = 1'b0; w16 = 1'b0;
        chk("async_count", 32'(bus10.count), 32'd0);
        chk("async_bar", 32'(bus10.count_bar), 32'hF);
        chk("async_wrap", 32'(bus10.wrap), 32'd0);
        chk("async_tc_up", 32'(bus10.tc), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        #1;
        chk("async_tc_dn", 32'(bus10.tc), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_hold", 32'(bus10.count), 32'd0);
        end
        #2 reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 4'h0);
        chk("first_edge", 32'(bus10.count), 32'd1);

        // Up-count through the wrap
        cyc(1'b0, 1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 4'h0);
        chk("up_end", 32'(bus10.count), 32'd2);

        // Down-count through the wrap
        cyc(1'b0, 1'b0, 1'b1, 4'h2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 4'h0);
        chk("down_end", 32'(bus10.count), 32'd8);

        // Load priority and saturation
        cyc(1'b1, 1'b1, 1'b1, 4'h6);
        chk("load6", 32'(bus10.count), 32'd6);
        cyc(1'b0, 1'b0, 1'b1, 4'd13);
        chk("load_sat", 32'(bus10.count), 32'd9);
        cyc(1'b1, 1'b1, 1'b1, 4'd15);
        chk("load15_m16", 32'(bus16.count), 32'd15);
        chk("load_nowrap", 32'(bus10.wrap), 32'd0);

        // Hold at 5: no excitation, no tc
        cyc(1'b0, 1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'h0);
            #1;
            chk("hold_j", 32'(dut10.j_s), 32'd0);
            chk("hold_k", 32'(dut10.k_s), 32'd0);
            cyc(1'b0, 1'b1, 1'b0, 4'h0);
        end
        chk("hold5", 32'(bus10.count), 32'd5);

        // 7 -> 8 toggles every cell
        cyc(1'b0, 1'b0, 1'b1, 4'h7);
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        #1;
        chk("tog_j", 32'(dut10.j_s), 32'hF);
        chk("tog_k", 32'(dut10.k_s), 32'hF);
        cyc(1'b1, 1'b1, 1'b0, 4'h0);

        // Hold at terminal count keeps tc and wrap low
        cyc(1'b0, 1'b0, 1'b1, 4'h9);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);

        // Direction flips on consecutive edges
        cyc(1'b0, 1'b0, 1'b1, 4'h4);
        cyc(1'b1, 1'b1, 1'b0, 4'h0);
        chk("flip5", 32'(bus10.count), 32'd5);
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        chk("flip4", 32'(bus10.count), 32'd4);
        cyc(1'b1, 1'b1, 1'b0, 4'h0);
        chk("flip5b", 32'(bus10.count), 32'd5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 9) == 0),
                4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
